// File: rtl/mem_access_unit_if.sv
// Bus bundle for the LC-3 memory access stage.
// slave = the access unit, master = ISDU/datapath/SRAM side.
interface mem_access_unit_if;
  logic [15:0] ADDR_IN;
  logic [15:0] BUS_IN;
  logic        MAR_SEL;
  logic        LD_MAR;
  logic        LD_MDR;
  logic        MEM_REQ;
  logic        MEM_WR;
  logic [15:0] SRAM_RDATA;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic [15:0] SRAM_ADDR;
  logic [15:0] SRAM_WDATA;
  logic        SRAM_CE;
  logic        SRAM_OE;
  logic        SRAM_WE;
  logic        BUSY;
  logic        MEM_RDY;

  modport slave (
    input  ADDR_IN, BUS_IN, MAR_SEL, LD_MAR, LD_MDR,
    input  MEM_REQ, MEM_WR, SRAM_RDATA,
    output MAR, MDR, SRAM_ADDR, SRAM_WDATA,
    output SRAM_CE, SRAM_OE, SRAM_WE, BUSY, MEM_RDY
  );

  modport master (
    output ADDR_IN, BUS_IN, MAR_SEL, LD_MAR, LD_MDR,
    output MEM_REQ, MEM_WR, SRAM_RDATA,
    input  MAR, MDR, SRAM_ADDR, SRAM_WDATA,
    input  SRAM_CE, SRAM_OE, SRAM_WE, BUSY, MEM_RDY
  );
endinterface

// File: rtl/mem_access_unit.sv
// LC-3 memory access stage: MAR/MDR plus a fixed-latency SRAM sequencer.
// Ports: Clk, Reset (sync, active-high), bus (slave side of the bundle).
module mem_access_unit #(
  parameter int unsigned LATENCY = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  mem_access_unit_if.slave bus
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.LD_MAR)
          mar_d = bus.MAR_SEL ? bus.ADDR_IN : bus.BUS_IN;
        if (bus.LD_MDR)
          mdr_d = bus.BUS_IN;
        state_d = IDLE;
        // Loads above land on the same edge, so the
        // new transaction sees the fresh MAR/MDR.
        if (bus.MEM_REQ) begin
          state_d = ACCESS;
          cnt_d   = CNT_INIT;
          is_wr_d = bus.MEM_WR;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!is_wr_q)
            mdr_d = bus.SRAM_RDATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      cnt_q   <= 4'd0;
      mar_q   <= 16'h0000;
      mdr_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
    end
  end

  // Strobes depend on registered state only.
  assign bus.MAR        = mar_q;
  assign bus.MDR        = mdr_q;
  assign bus.SRAM_ADDR  = mar_q;
  assign bus.SRAM_WDATA = mdr_q;
  assign bus.SRAM_CE    = (state_q == ACCESS);
  assign bus.SRAM_OE    = (state_q == ACCESS) && !is_wr_q;
  assign bus.SRAM_WE    = (state_q == ACCESS) && is_wr_q;
  assign bus.BUSY       = (state_q == ACCESS) ||
                          (state_q == DONE);
  assign bus.MEM_RDY    = (state_q == DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: three builds (LATENCY 2, 1, 15)
// share one stimulus and are compared to a timestamp model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr_in, bus_in, rdata;
  logic        mar_sel, ld_mar, ld_mdr, mem_req, mem_wr;

  always #5 clk = ~clk;

  logic [15:0] o_mar[3], o_mdr[3], o_addr[3], o_wdata[3];
  logic [2:0]  o_ce, o_oe, o_we, o_busy, o_rdy;

  function automatic int lat_of(int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 15;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_access_unit_if ifc ();
    assign ifc.ADDR_IN    = addr_in;
    assign ifc.BUS_IN     = bus_in;
    assign ifc.MAR_SEL    = mar_sel;
    assign ifc.LD_MAR     = ld_mar;
    assign ifc.LD_MDR     = ld_mdr;
    assign ifc.MEM_REQ    = mem_req;
    assign ifc.MEM_WR     = mem_wr;
    assign ifc.SRAM_RDATA = rdata;
    mem_access_unit #(.LATENCY(lat_of(g))) u_dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (ifc)
    );
    assign o_mar[g]   = ifc.MAR;
    assign o_mdr[g]   = ifc.MDR;
    assign o_addr[g]  = ifc.SRAM_ADDR;
    assign o_wdata[g] = ifc.SRAM_WDATA;
    assign o_ce[g]    = ifc.SRAM_CE;
    assign o_oe[g]    = ifc.SRAM_OE;
    assign o_we[g]    = ifc.SRAM_WE;
    assign o_busy[g]  = ifc.BUSY;
    assign o_rdy[g]   = ifc.MEM_RDY;
  end

  int n_chk = 0;
  int n_pass = 0;

  // Model: a transaction requested in cycle t owns ACCESS
  // cycles t+1..t+L and DONE cycle t+L+1.
  int          cyc = 0;
  bit          chk_en = 0;
  bit          m_act[3];
  bit          m_wr[3];
  int          m_treq[3];
  logic [15:0] m_mar[3], m_mdr[3];

  function automatic bit in_acc(int i, int c);
    return m_act[i] && c >= m_treq[i] + 1 &&
           c <= m_treq[i] + lat_of(i);
  endfunction

  function automatic bit in_done(int i, int c);
    return m_act[i] && c == m_treq[i] + lat_of(i) + 1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_act[i] = 0;
        m_wr[i]  = 0;
        m_mar[i] = 16'h0;
        m_mdr[i] = 16'h0;
      end else if (in_acc(i, cyc)) begin
        if (!m_wr[i] && cyc == m_treq[i] + lat_of(i))
          m_mdr[i] = rdata;
      end else begin
        if (ld_mar) m_mar[i] = mar_sel ? addr_in : bus_in;
        if (ld_mdr) m_mdr[i] = bus_in;
        if (mem_req) begin
          m_act[i]  = 1;
          m_treq[i] = cyc;
          m_wr[i]   = mem_wr;
        end
      end
    end
    if (rst) chk_en = 1;
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        logic [68:0] got, exp;
        bit a, d;
        a = in_acc(i, cyc);
        d = in_done(i, cyc);
        exp = {m_mar[i], m_mdr[i], m_mar[i], m_mdr[i],
               a, a && !m_wr[i], a && m_wr[i], a || d, d};
        got = {o_mar[i], o_mdr[i], o_addr[i], o_wdata[i],
               o_ce[i], o_oe[i], o_we[i], o_busy[i], o_rdy[i]};
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL model[L=%0d] cyc %0d: got %h want %h",
                      lat_of(i), cyc, got, exp);
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  int ce_n[3], oe_n[3], we_n[3], rdy_n[3], first[3];
  int tcnt;

  task automatic clr();
    tcnt = 0;
    for (int i = 0; i < 3; i++) begin
      ce_n[i] = 0; oe_n[i] = 0; we_n[i] = 0;
      rdy_n[i] = 0; first[i] = -1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    tcnt++;
    for (int i = 0; i < 3; i++) begin
      ce_n[i]  += int'(o_ce[i]);
      oe_n[i]  += int'(o_oe[i]);
      we_n[i]  += int'(o_we[i]);
      rdy_n[i] += int'(o_rdy[i]);
      if (o_rdy[i] && first[i] < 0) first[i] = tcnt;
    end
  endtask

  task automatic rnd_in();
    addr_in = 16'($urandom);
    bus_in  = 16'($urandom);
    rdata   = 16'($urandom);
    mar_sel = 1'($urandom);
    ld_mar  = 1'($urandom);
    ld_mdr  = 1'($urandom);
    mem_req = 1'($urandom);
    mem_wr  = 1'($urandom);
  endtask

  task automatic idle_in();
    ld_mar = 0; ld_mdr = 0; mem_req = 0; mem_wr = 0;
    mar_sel = 0;
  endtask

  initial begin
    rst = 1;
    rnd_in();
    clr();
    tick(); rnd_in();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_mar%0d", i), int'(o_mar[i]), 0);
      chk($sformatf("rst_mdr%0d", i), int'(o_mdr[i]), 0);
      chk($sformatf("rst_ctl%0d", i),
          int'({o_ce[i], o_oe[i], o_we[i], o_busy[i], o_rdy[i]}), 0);
    end
    rst = 0;
    idle_in();
    tick();

    // read, MAR loaded on the request edge
    addr_in = 16'h3000; mar_sel = 1; ld_mar = 1;
    mem_req = 1; mem_wr = 0; rdata = 16'h0;
    clr();
    tick();
    chk("rd_addr", int'(o_addr[0]), 16'h3000);
    ld_mar = 0; mem_req = 0; rdata = 16'hBEEF;
    repeat (19) tick();
    chk("rd_ce", ce_n[0], 2);
    chk("rd_oe", oe_n[0], 2);
    chk("rd_we", we_n[0], 0);
    chk("rd_lat2", first[0], 3);
    chk("rd_lat1", first[1], 2);
    chk("rd_lat15", first[2], 16);
    chk("rd_ce1", ce_n[1], 1);
    chk("rd_ce15", ce_n[2], 15);
    chk("rd_pulses", rdy_n[0], 1);
    chk("rd_mdr", int'(o_mdr[0]), 16'hBEEF);

    // write
    bus_in = 16'h1234; ld_mdr = 1;
    tick();
    bus_in = 16'h00FF; mar_sel = 0; ld_mar = 1; ld_mdr = 0;
    tick();
    ld_mar = 0; mem_req = 1; mem_wr = 1;
    clr();
    tick();
    mem_req = 0;
    chk("wr_addr", int'(o_addr[0]), 16'h00FF);
    chk("wr_wdata", int'(o_wdata[0]), 16'h1234);
    repeat (19) tick();
    chk("wr_we", we_n[0], 2);
    chk("wr_oe", oe_n[0], 0);
    chk("wr_ce", ce_n[0], 2);
    chk("wr_pulses", rdy_n[0], 1);
    chk("wr_mdr", int'(o_mdr[0]), 16'h1234);

    // interlock and back-to-back
    mem_req = 1; mem_wr = 0; rdata = 16'h1111;
    clr();
    tick();
    ld_mar = 1; mar_sel = 1; addr_in = 16'hFFFF;
    ld_mdr = 1; bus_in = 16'h5555;
    tick();
    chk("il_mar", int'(o_mar[0]), 16'h00FF);
    chk("il_mdr", int'(o_mdr[0]), 16'h1234);
    tick();
    chk("il_mar2", int'(o_mar[0]), 16'h00FF);
    chk("il_mdr2", int'(o_mdr[0]), 16'h1111);
    chk("il_rdy", int'(o_rdy[0]), 1);
    ld_mar = 0; ld_mdr = 0;
    tick();
    chk("il_b2b", int'(o_ce[0]), 1);
    mem_req = 0;
    repeat (18) tick();
    chk("il_pulses", rdy_n[0], 2);
    chk("il_ce", ce_n[0], 4);

    // reset in the first ACCESS cycle of a read
    mem_req = 1; mem_wr = 0;
    clr();
    tick();
    rst = 1; rdata = 16'hAAAA; mem_req = 0;
    tick();
    chk("rs_mdr", int'(o_mdr[0]), 0);
    chk("rs_busy", int'(o_busy[0]), 0);
    chk("rs_ce", int'(o_ce[0]), 0);
    rst = 0;
    repeat (5) tick();
    chk("rs_rdy", rdy_n[0], 0);

    // random traffic against the model
    repeat (3000) begin
      tick();
      rnd_in();
      mem_req = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 63) == 0);
    end
    rst = 0;
    idle_in();
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

LC-3 memory access stage holding MAR and MDR and sequencing one SRAM read or write per request. Sits directly downstream of the address adder: MAR loads from the adder's effective address or from the datapath bus. A fixed-latency SRAM cycle then runs under control of the ISDU, and read data lands in MDR.

## Interface
Parameters:
- LATENCY, 2, SRAM access cycles per transaction; legal range 1..15 (4-bit counter)

Ports:
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; dominant over every other input
- ADDR_IN  in  16  effective address from the address adder
- BUS_IN  in  16  datapath bus
- MAR_SEL  in  1  MAR source: 1 = ADDR_IN, 0 = BUS_IN
- LD_MAR  in  1  load MAR
- LD_MDR  in  1  load MDR from BUS_IN
- MEM_REQ  in  1  start transaction (sampled only in IDLE or DONE)
- MEM_WR  in  1  transaction type, sampled with MEM_REQ: 1 = write, 0 = read
- SRAM_RDATA  in  16  SRAM read data
- MAR  out  16  memory address register
- MDR  out  16  memory data register
- SRAM_ADDR  out  16  equals MAR
- SRAM_WDATA  out  16  equals MDR
- SRAM_CE  out  1  chip enable, high for whole ACCESS phase
- SRAM_OE  out  1  high during ACCESS of a read
- SRAM_WE  out  1  high during ACCESS of a write
- BUSY  out  1  high in ACCESS and DONE
- MEM_RDY  out  1  one-cycle completion pulse (DONE state)

## Operation
- States: IDLE, ACCESS, DONE. Registered type bit `is_wr`; 4-bit down-counter `cnt`.
- IDLE: LD_MAR/LD_MDR honoured. MEM_REQ=1 -> ACCESS, cnt <= LATENCY-1, is_wr <= MEM_WR.
- ACCESS: SRAM_CE=1, SRAM_OE=!is_wr, SRAM_WE=is_wr. cnt decrements each cycle. At cnt==0 -> DONE. On a read, MDR <= SRAM_RDATA on that same edge.
- DONE: MEM_RDY=1.
  - MEM_REQ=1 -> ACCESS (back-to-back).
  - Otherwise -> IDLE.
  - LD_MAR/LD_MDR honoured in DONE.
- LD_MAR and LD_MDR are ignored in ACCESS, so MAR and MDR stay stable for the whole transaction.
- Same-edge load + request (IDLE or DONE): the register load takes effect and the transaction uses the newly loaded value. ACCESS starts the next cycle, so no bypass is needed.
- MEM_REQ in ACCESS is ignored (not queued).
- Strobes and BUSY/MEM_RDY are decoded combinationally from state/is_wr only. No glitch dependence on inputs.
- Reset: state=IDLE, MAR=0x0000, MDR=0x0000, is_wr=0, cnt=0. Hence all strobes=0, BUSY=0, MEM_RDY=0, SRAM_ADDR=SRAM_WDATA=0x0000.
- Reset mid-ACCESS aborts the transaction. MDR clears to 0x0000, not the partial read. Strobes drop in the cycle after the reset edge.

## Timing
- MEM_REQ sampled at edge t (IDLE) -> ACCESS occupies cycles t+1 .. t+LATENCY -> DONE at cycle t+LATENCY+1 -> IDLE at t+LATENCY+2 if no new request.
- Read data must be valid on SRAM_RDATA in the last ACCESS cycle; MDR shows it from the DONE cycle on.
- Request-to-MEM_RDY latency: LATENCY+1 cycles. Back-to-back throughput: one transaction per LATENCY+1 cycles.
- LATENCY=1: single ACCESS cycle, cnt starts at 0.
- MAR/MDR loads visible at outputs the cycle after the load edge.

## Test plan
- Reset values: assert Reset 2 cycles with random inputs -> MAR=MDR=0x0000, SRAM_CE/OE/WE=0, BUSY=0, MEM_RDY=0.
- Read, LATENCY=2: ADDR_IN=0x3000, MAR_SEL=1, LD_MAR=1 with MEM_REQ=1, MEM_WR=0 at edge t; model returns 0xBEEF -> SRAM_ADDR=0x3000, CE/OE high cycles t+1..t+2, MDR=0xBEEF and MEM_RDY=1 at t+3 only.
- Write: BUS_IN=0x1234 with LD_MDR=1; then BUS_IN=0x00FF with MAR_SEL=0, LD_MAR=1; then MEM_REQ=1, MEM_WR=1 -> CE/WE high 2 cycles, SRAM_ADDR=0x00FF, SRAM_WDATA=0x1234, OE=0 throughout.
- Interlock: during ACCESS drive LD_MAR=1 (ADDR_IN=0xFFFF), LD_MDR=1, MEM_REQ=1 -> MAR/MDR unchanged, no extra transaction. A MEM_REQ held in DONE starts the next ACCESS immediately, with MEM_RDY pulsing exactly once per transaction.
- Reset mid-read: assert Reset in first ACCESS cycle with SRAM_RDATA=0xAAAA -> IDLE, MDR=0x0000, no MEM_RDY pulse.
- LATENCY=1 and LATENCY=15 builds: request -> MEM_RDY after exactly 2 and 16 cycles; CE high exactly 1 and 15 cycles.
